// File: rtl/fpmul_pkg.sv
// Shared definitions for the FP32 multiplier scheduler.
//   state_e          : scheduler FSM state encoding
//   FP32_QNAN        : product reported when the core never answers
//   TIMEOUT_DEFAULT  : default watchdog limit in cycles
//   CNT_W_DEFAULT    : default watchdog counter width
package fpmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [31:0] FP32_QNAN       = 32'h7FFF_FFFF;
  localparam int          TIMEOUT_DEFAULT = 16;
  localparam int          CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/fpmul_sched_rr_arb2.sv
// Two-request round-robin arbiter with a combinational grant.
//   clk, rst_n : clock, synchronous active-low reset
//   req_i      : request vector, bit n = requester n
//   accept_i   : the current grant was taken; pointer moves to it
//   gnt_o      : one-hot grant (zero when no request)
//   gnt_id_o   : index of the granted requester
// The pointer holds the last granted ID; on contention the other
// requester wins. After reset the pointer is 1 so requester 0 wins first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q;

  always_comb begin
    gnt_id_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_id_o = ~ptr_q;
    end else if (req_i[1]) begin
      gnt_id_o = 1'b1;
    end
    gnt_o = 2'b00;
    if (req_i != 2'b00) begin
      gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
    end else if (accept_i) begin
      ptr_q <= gnt_id_o;
    end
  end

endmodule

// File: rtl/fpmul_sched.sv
// Round-robin scheduler sharing one external FP32 multiplier core
// between two requesters, with a watchdog on the core.
//   clk, rst_n          : clock, synchronous active-low reset
//   reqN_valid/ready    : requester N operand handshake (N = 0, 1)
//   reqN_A, reqN_B      : requester N operands (IEEE-754 single)
//   core_start          : one-cycle launch pulse to the core
//   core_A, core_B      : registered operands, held until the next accept
//   core_done, core_S   : core result pulse and value
//   rsp_valid/ready     : response handshake
//   rsp_id, rsp_S       : requester ID and product (QNaN on timeout)
//   rsp_err             : 1 when the watchdog fired
//   busy                : FSM not in IDLE
//   dbg_state           : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. Valid never waits on ready; once rsp_valid is high the
// response fields hold until the transfer. reqN_ready is only ever high
// in IDLE, so it has no path from rsp_ready.
module fpmul_sched
  import fpmul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  output logic        core_start,
  output logic [31:0] core_A,
  output logic [31:0] core_B,
  input  logic        core_done,
  input  logic [31:0] core_S,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_S,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // WAIT is left by timeout once the counter, after this cycle's
  // increment, would reach TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             id_q;
  logic             core_start_q;
  logic [31:0]      core_a_q;
  logic [31:0]      core_b_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [31:0]      rsp_s_q;
  logic             rsp_err_q;
  logic             busy_q;

  logic             in_idle;
  logic [1:0]       arb_req;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic             accept;

  // Readiness is suppressed while reset is asserted so no requester sees
  // a handshake that the reset branch would discard.
  assign in_idle = (state_q == ST_IDLE) && rst_n;
  assign arb_req = {req1_valid, req0_valid} & {2{in_idle}};
  assign accept  = |gnt;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (arb_req),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_s_q      <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            core_a_q     <= gnt_id ? req1_A : req0_A;
            core_b_q     <= gnt_id ? req1_B : req0_B;
            id_q         <= gnt_id;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done in the timeout cycle still yields a normal response.
          if (core_done) begin
            rsp_s_q     <= core_S;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_s_q     <= FP32_QNAN;
            rsp_err_q   <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign core_start = core_start_q;
  assign core_A     = core_a_q;
  assign core_B     = core_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_S      = rsp_s_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/fpmul_sched.md
Name: fpmul_sched

Overview:
- Round-robin scheduler that shares one FP32 multiplier core (vedic mantissa multiplier plus special-case resolver) between two requesters.
- Accepts operand pairs over valid/ready and issues a one-cycle start to the core.
- Waits for the core's done, then returns the product, requester ID and an error flag over a valid/ready response port.
- A watchdog converts a hung core into a NaN error response.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT before forcing an error response; legal range 2..255.
- CNT_W, 8: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req0_A  in  32  requester 0 operand A, IEEE-754 single.
- req0_B  in  32  requester 0 operand B.
- req1_valid, req1_ready, req1_A, req1_B: same as requester 0, for requester 1.
- core_start  out  1  one-cycle pulse launching the core.
- core_A  out  32  registered operand A to the core.
- core_B  out  32  registered operand B to the core.
- core_done  in  1  core result valid, one-cycle pulse.
- core_S  in  32  core result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester ID of the response.
- rsp_S  out  32  product, or 32'h7FFFFFFF on timeout.
- rsp_err  out  1  1 = watchdog timeout.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State IDLE; last-grant pointer = 1, so requester 0 wins first.
  - Watchdog counter = 0.
  - All outputs = 0: ready, start, core_A/B, rsp_*, busy.
- Reset mid-operation abandons the transaction. A core_done arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Ready signals are combinational from valid and the pointer; no other state asserts them.
  - Only one valid: that requester gets ready=1.
  - Both valid: grant goes to the requester not equal to the pointer.
  - On a handshake: capture A/B into core_A/core_B, record the ID, update the pointer to the granted ID, go to ISSUE.
  - Neither valid: stay in IDLE.
- ISSUE:
  - core_start=1 for exactly this cycle; counter cleared; go to WAIT.
- WAIT:
  - core_done=1: capture core_S into rsp_S, rsp_err=0, go to RESP.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT-1 with no done: rsp_S=32'h7FFFFFFF, rsp_err=1, go to RESP.
  - A done in the same cycle as the timeout wins; the response is normal.
- RESP:
  - rsp_valid=1. rsp_S, rsp_id and rsp_err stay stable until rsp_ready=1.
  - Return to IDLE on the cycle after the handshake; rsp_valid drops.
- Latency:
  - Accept at cycle T; core_start at T+1.
  - Core done at T+1+k (k≥1) gives rsp_valid at T+2+k.
  - Minimum accept-to-accept spacing is 4 cycles (k=1, rsp_ready held high).
- core_done outside WAIT (IDLE, ISSUE, RESP) is ignored, with no state change.
- core_A and core_B hold their value until the next accept.
- busy = (state != IDLE).
- No combinational path from rsp_ready to req*_ready: a new accept happens only in IDLE.

Decomposition:
- Shared package fpmul_pkg:
  - State encoding constants: ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3.
  - FP32_QNAN = 32'h7FFFFFFF.
  - Default TIMEOUT.
- Sub-module rr_arb2:
  - Two-request round-robin arbiter, combinational grant.
  - Pointer register updated on the accept strobe.
  - Synchronous active-low reset.
- The rest is one FSM module. The core itself is external.

Test Plan:
- Single request: req0 with A=0x40400000, B=0x40000000; core model k=3 returning 0x40C00000 → req0_ready at T; core_start at T+1; rsp_valid at T+5 with rsp_S=0x40C00000, rsp_id=0, rsp_err=0.
- Contention: req0 and req1 held valid continuously for 4 transactions → grant order 0,1,0,1; each core_A matches the granted requester's A; rsp_id sequence 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP while req1 is valid → rsp_S, rsp_id and rsp_valid stay stable; req1_ready stays 0; req1 is accepted the cycle after IDLE is re-entered.
- Watchdog: TIMEOUT=8, core never asserts done → rsp_valid 8 cycles after core_start with rsp_S=0x7FFFFFFF, rsp_err=1. Repeat with done on the final WAIT cycle → normal response, err=0.
- Reset in WAIT: rst_n=0 for one cycle mid-WAIT → next cycle all outputs 0 and busy=0. A core_done two cycles later produces no rsp_valid, and the next request is served normally.
- Spurious done: core_done pulsed in IDLE and in RESP → no state change and no rsp_S update.
